// File: rtl/mux2_stream_arb_pkg.sv
// Shared definitions for the 2-to-1 stream arbiter.
// Contents: default widths, source-select codes and a one-hot grant helper.
package mux2_stream_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  typedef logic [1:0] grant_t;

  // One-hot grant vector for a channel index.
  function automatic grant_t sel_onehot(input logic id);
    return (id == SEL_IN1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mux2_stream_arb_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin arbiter with packet lock.
// Ports:
//   req[1:0]  request vector (bit X = channel X valid)
//   prio      channel that wins when both request
//   lock      grant held to lock_id while set
//   lock_id   channel owning the lock
//   grant     one-hot (or zero) grant vector
module rr_arb2
  import mux2_stream_arb_pkg::*;
(
  input  logic   [1:0] req,
  input  logic         prio,
  input  logic         lock,
  input  logic         lock_id,
  output grant_t       grant
);

  // Lock overrides arbitration; otherwise tie goes to prio, single request wins.
  always_comb begin
    grant = 2'b00;
    if (lock) begin
      if (req[lock_id]) grant = sel_onehot(lock_id);
    end else if (req == 2'b11) begin
      grant = sel_onehot(prio);
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mux2_stream_arb.sv
// mux2_stream_arb: merges two valid/ready channels into one registered sink
// channel with round-robin arbitration and saturating per-channel beat counters.
// Optional feature macro: MUX2_STREAM_ARB_PKT_LOCK_EN (packets never interleave).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in0_valid/ready/data/last      source channel 0
//   in1_valid/ready/data/last      source channel 1
//   out_valid/ready/data/last      registered sink channel
//   out_sel                        source of current out beat (0 = in0, 1 = in1)
//   cnt0, cnt1                     accepted-beat counters, saturating
module mux2_stream_arb
  import mux2_stream_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic   space_c;
  logic   prio;
  logic   lock;
  logic   lock_id;
  grant_t grant_c;
  logic   acc0_c;
  logic   acc1_c;
  logic   acc_c;
  logic   acc_id_c;
  logic   acc_last_c;

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .prio    (prio),
    .lock    (lock),
    .lock_id (lock_id),
    .grant   (grant_c)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign space_c   = ~out_valid | out_ready;
  assign in0_ready = space_c & grant_c[0] & rst_n;
  assign in1_ready = space_c & grant_c[1] & rst_n;

  assign acc0_c     = in0_valid & in0_ready;
  assign acc1_c     = in1_valid & in1_ready;
  assign acc_c      = acc0_c | acc1_c;
  assign acc_id_c   = acc1_c ? SEL_IN1 : SEL_IN0;
  assign acc_last_c = acc1_c ? in1_last : in0_last;

  // Output register, counters and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= SEL_IN0;
      cnt0      <= '0;
      cnt1      <= '0;
      prio      <= SEL_IN0;
    end else begin
      if (acc_c) begin
        out_valid <= 1'b1;
        out_data  <= acc1_c ? in1_data : in0_data;
        out_last  <= acc_last_c;
        out_sel   <= acc_id_c;
`ifdef MUX2_STREAM_ARB_PKT_LOCK_EN
        if (acc_last_c) prio <= ~acc_id_c;
`else
        prio <= ~acc_id_c;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc0_c && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + CNT_W'(1);
      if (acc1_c && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

`ifdef MUX2_STREAM_ARB_PKT_LOCK_EN
  // Lock grant to the source of an open packet until its last beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_id <= SEL_IN0;
    end else if (acc_c) begin
      lock    <= ~acc_last_c;
      lock_id <= acc_id_c;
    end
  end
`else
  assign lock    = 1'b0;
  assign lock_id = SEL_IN0;
`endif

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Directed self-checking bench for mux2_stream_arb (main instance CNT_W=16,
// second instance CNT_W=2 sharing the same stimulus for saturation checks).
module tb_mux2_stream_arb;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in0_valid, in1_valid, in0_last, in1_last, out_ready;
  logic [DW-1:0] in0_data, in1_data;
  logic          in0_ready, in1_ready, out_valid, out_last, out_sel;
  logic [DW-1:0] out_data;
  logic [15:0]   cnt0, cnt1;

  logic          s_in0_ready, s_in1_ready, s_out_valid, s_out_last, s_out_sel;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_cnt0, s_cnt1;

  int vecs = 0;
  int errs = 0;

  mux2_stream_arb #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .cnt0(cnt0), .cnt1(cnt1)
  );

  mux2_stream_arb #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(s_in0_ready), .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_ready(s_in1_ready), .in1_data(in1_data), .in1_last(in1_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last),
    .out_sel(s_out_sel), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_last  = 1'b0; in1_last  = 1'b0;
    in0_data  = '0;   in1_data  = '0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_cnt0", 32'(cnt0), 32'h0);
    chk("rst_cnt1", 32'(cnt1), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    #12;
    // Reset state, ready low during reset even with valid inputs.
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_out_last", 32'(out_last), 32'h0);
    chk("reset_out_sel", 32'(out_sel), 32'h0);
    chk("reset_cnt0", 32'(cnt0), 32'h0);
    chk("reset_cnt1", 32'(cnt1), 32'h0);
    chk("reset_in0_ready", 32'(in0_ready), 32'h0);
    chk("reset_in1_ready", 32'(in1_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;

    // Both valid every cycle: alternation starting with in0.
    in0_data = 8'hA0; in1_data = 8'hB0;
    chk("alt_first_in0_ready", 32'(in0_ready), 32'h1);
    chk("alt_first_in1_ready", 32'(in1_ready), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("alt_out_valid", 32'(out_valid), 32'h1);
      chk("alt_out_sel", 32'(out_sel), 32'(i % 2));
      chk("alt_out_data", 32'(out_data), (i % 2 == 0) ? 32'hA0 : 32'hB0);
    end
    chk("alt_cnt0", 32'(cnt0), 32'd4);
    chk("alt_cnt1", 32'(cnt1), 32'd4);
    chk("alt_sat_cnt0", 32'(s_cnt0), 32'd3);
    idle_inputs();
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_hold_data", 32'(out_data), 32'hB0);
    chk("drain_hold_sel", 32'(out_sel), 32'h1);

    // Only in0: 0x11,0x22,0x33 back-to-back.
    in0_valid = 1'b1; in0_data = 8'h11;
    tick();
    chk("seq_out_11", 32'(out_data), 32'h11);
    chk("seq_sel_0a", 32'(out_sel), 32'h0);
    in0_data = 8'h22;
    tick();
    chk("seq_out_22", 32'(out_data), 32'h22);
    chk("seq_valid_22", 32'(out_valid), 32'h1);
    in0_data = 8'h33; in0_last = 1'b1;
    tick();
    chk("seq_out_33", 32'(out_data), 32'h33);
    chk("seq_last_33", 32'(out_last), 32'h1);
    chk("seq_cnt0", 32'(cnt0), 32'd7);
    idle_inputs();
    tick();
    chk("seq_drain", 32'(out_valid), 32'h0);

    // Stall: out_ready low for 3 cycles with out_valid=1.
    in0_valid = 1'b1; in0_data = 8'h5A;
    tick();
    chk("stall_load", 32'(out_data), 32'h5A);
    out_ready = 1'b0;
    in0_data = 8'h6B; in1_valid = 1'b1; in1_data = 8'h7C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in0_ready", 32'(in0_ready), 32'h0);
      chk("stall_in1_ready", 32'(in1_ready), 32'h0);
      tick();
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_data", 32'(out_data), 32'h5A);
      chk("stall_sel", 32'(out_sel), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in1_ready", 32'(in1_ready), 32'h1);
    chk("release_in0_ready", 32'(in0_ready), 32'h0);
    tick();
    chk("release_b1", 32'(out_data), 32'h7C);
    tick();
    chk("release_b2", 32'(out_data), 32'h6B);
    tick();
    chk("release_b3", 32'(out_data), 32'h7C);
    chk("release_valid", 32'(out_valid), 32'h1);

    // Reset mid-stream: output cleared immediately, tie goes to in0 after release.
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_cnt0", 32'(cnt0), 32'h0);
    chk("midrst_cnt1", 32'(cnt1), 32'h0);
    chk("midrst_in1_ready", 32'(in1_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    in0_data = 8'h91; in1_data = 8'hC1;
    tick();
    chk("postrst_sel", 32'(out_sel), 32'h0);
    chk("postrst_data", 32'(out_data), 32'h91);
    chk("postrst_cnt0", 32'(cnt0), 32'd1);
    chk("postrst_cnt1", 32'(cnt1), 32'd0);
    idle_inputs();
    tick();

    // Saturation: 5 beats from in1 on a 2-bit counter stops at 3.
    do_reset();
    in1_valid = 1'b1; in1_data = 8'hE5;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt1_w2", 32'(s_cnt1), 32'd3);
    chk("sat_cnt1_w16", 32'(cnt1), 32'd5);
    chk("sat_cnt0_w2", 32'(s_cnt0), 32'd0);
    idle_inputs();
    tick();

    // in0 3-beat packet with in1 valid throughout.
    do_reset();
    in1_valid = 1'b1; in1_data = 8'hD0; in1_last = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h01; in0_last = 1'b0;
    tick();
    chk("pkt_b1_sel", 32'(out_sel), 32'h0);
    chk("pkt_b1_data", 32'(out_data), 32'h01);
`ifdef MUX2_STREAM_ARB_PKT_LOCK_EN
    in0_valid = 1'b0;
    #1;
    chk("pkt_lock_in1_ready", 32'(in1_ready), 32'h0);
    in0_valid = 1'b1; in0_data = 8'h02;
    tick();
    chk("pkt_b2_sel", 32'(out_sel), 32'h0);
    chk("pkt_b2_data", 32'(out_data), 32'h02);
    in0_data = 8'h03; in0_last = 1'b1;
    tick();
    chk("pkt_b3_sel", 32'(out_sel), 32'h0);
    chk("pkt_b3_last", 32'(out_last), 32'h1);
    in0_data = 8'h04; in0_last = 1'b0;
    tick();
    chk("pkt_after_sel", 32'(out_sel), 32'h1);
    chk("pkt_after_data", 32'(out_data), 32'hD0);
`else
    in0_data = 8'h02;
    tick();
    chk("nolock_b2_sel", 32'(out_sel), 32'h1);
    chk("nolock_b2_data", 32'(out_data), 32'hD0);
    tick();
    chk("nolock_b3_sel", 32'(out_sel), 32'h0);
    chk("nolock_b3_data", 32'(out_data), 32'h02);
`endif
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
